// File: rtl/cpu_pkg.sv
// Shared opcode, FSM state and ALU-operation encodings for the multi-cycle controller.
package cpu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [3:0] {
        ST_IF     = 4'b0000,
        ST_ID     = 4'b0001,
        ST_EXE_LS = 4'b0010,
        ST_MEM    = 4'b0011,
        ST_WB_LD  = 4'b0100,
        ST_EXE_BR = 4'b0101,
        ST_EXE_AL = 4'b0110,
        ST_WB_AL  = 4'b0111,
        ST_HALT   = 4'b1000
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_RS   = 2'b10;
    localparam logic [1:0] PC_JUMP = 2'b11;

    // IC_JMP also covers undefined opcodes: both finish in ID.
    typedef enum logic [2:0] {
        IC_ALU,
        IC_BR,
        IC_LS,
        IC_JMP,
        IC_HALT
    } iclass_e;

    function automatic iclass_e op_class(input logic [5:0] op);
        iclass_e c;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR,
            OP_AND, OP_ORI, OP_SLL, OP_SLT: c = IC_ALU;
            OP_BEQ, OP_BNE:                 c = IC_BR;
            OP_LW, OP_SW:                   c = IC_LS;
            OP_HALT:                        c = IC_HALT;
            default:                        c = IC_JMP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: every datapath enable and select from opcode and FSM state.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [5:0] op_i,
    input  state_e     state_i,
    input  logic       zero_i,
    input  logic       mem_done_i,
    output logic       pc_wre_o,
    output logic       ir_wre_o,
    output logic       reg_wre_o,
    output logic       ins_mem_rw_o,
    output logic       m_rd_o,
    output logic       m_wr_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic       ext_sel_o,
    output logic       db_data_src_o,
    output logic       wr_reg_d_src_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_op_o,
    output logic       halted_o
);

    logic is_lw, is_sw, is_beq, is_bne;

    assign is_lw  = (op_i == OP_LW);
    assign is_sw  = (op_i == OP_SW);
    assign is_beq = (op_i == OP_BEQ);
    assign is_bne = (op_i == OP_BNE);

    always_comb begin
        pc_wre_o       = 1'b0;
        ir_wre_o       = 1'b0;
        reg_wre_o      = 1'b0;
        ins_mem_rw_o   = 1'b0;
        m_rd_o         = 1'b0;
        m_wr_o         = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = 1'b0;
        ext_sel_o      = 1'b0;
        db_data_src_o  = 1'b0;
        wr_reg_d_src_o = 1'b0;
        reg_dst_o      = 2'b00;
        pc_src_o       = PC_NEXT;
        alu_op_o       = ALU_ADD;
        halted_o       = 1'b0;

        // Selects stay at 0 in IF and HALT so reset and halt present a quiet datapath.
        if (state_i != ST_IF && state_i != ST_HALT) begin
            ext_sel_o      = (op_i != OP_ORI);
            alu_src_a_o    = (op_i == OP_SLL);
            alu_src_b_o    = (op_i == OP_ADDI) || (op_i == OP_ORI) || is_lw || is_sw;
            db_data_src_o  = is_lw;
            wr_reg_d_src_o = (op_i == OP_JAL);
            case (op_i)
                OP_ADDI, OP_ORI, OP_LW:      reg_dst_o = 2'b01;
                OP_ADD, OP_SUB, OP_OR,
                OP_AND, OP_SLL, OP_SLT:      reg_dst_o = 2'b10;
                default:                     reg_dst_o = 2'b00;
            endcase
            case (op_i)
                OP_SUB, OP_BEQ, OP_BNE:      alu_op_o = ALU_SUB;
                OP_SLL:                      alu_op_o = ALU_SLL;
                OP_OR, OP_ORI:               alu_op_o = ALU_OR;
                OP_AND:                      alu_op_o = ALU_AND;
                OP_SLT:                      alu_op_o = ALU_SLT;
                default:                     alu_op_o = ALU_ADD;
            endcase
        end

        case (state_i)
            ST_IF: begin
                ir_wre_o     = 1'b1;
                ins_mem_rw_o = 1'b1;
            end
            ST_ID: begin
                pc_wre_o  = (op_class(op_i) == IC_JMP);
                reg_wre_o = (op_i == OP_JAL);
                if (op_i == OP_J || op_i == OP_JAL) begin
                    pc_src_o = PC_JUMP;
                end else if (op_i == OP_JR) begin
                    pc_src_o = PC_RS;
                end
            end
            ST_EXE_BR: begin
                pc_wre_o = 1'b1;
                if ((is_beq && zero_i) || (is_bne && !zero_i)) begin
                    pc_src_o = PC_BR;
                end
            end
            ST_MEM: begin
                m_rd_o   = is_lw;
                m_wr_o   = is_sw;
                pc_wre_o = is_sw && mem_done_i;
            end
            ST_WB_AL, ST_WB_LD: begin
                reg_wre_o = 1'b1;
                pc_wre_o  = 1'b1;
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: FSM state register plus next-state logic; outputs come from ctrl_decode.
// state  | meaning
// IF     | fetch, write IR
// ID     | decode; jumps, jal link and nop retire here
// EXE_AL | ALU operation
// WB_AL  | ALU result to register file
// EXE_BR | branch compare and PC update
// EXE_LS | address calculation for lw/sw
// MEM    | data memory access, waits on mem_ready when enabled
// WB_LD  | load data to register file
// HALT   | stopped until reset
module multi_cycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned ALUOP_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               InsMemRw,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         PcSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state,
    output logic               halted
);

    state_e     state_q, state_d;
    logic       mem_done;
    logic [2:0] alu_op3;

    assign mem_done = (MEM_WAIT_EN == 0) || mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:     state_d = ST_ID;
            ST_ID: begin
                case (op_class(op))
                    IC_JMP:  state_d = ST_IF;
                    IC_HALT: state_d = ST_HALT;
                    IC_BR:   state_d = ST_EXE_BR;
                    IC_LS:   state_d = ST_EXE_LS;
                    default: state_d = ST_EXE_AL;
                endcase
            end
            ST_EXE_AL: state_d = ST_WB_AL;
            ST_WB_AL:  state_d = ST_IF;
            ST_EXE_BR: state_d = ST_IF;
            ST_EXE_LS: state_d = ST_MEM;
            ST_MEM: begin
                if (mem_done) begin
                    state_d = (op == OP_LW) ? ST_WB_LD : ST_IF;
                end
            end
            ST_WB_LD:  state_d = ST_IF;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IF;
        endcase
    end

    ctrl_decode u_decode (
        .op_i           (op),
        .state_i        (state_q),
        .zero_i         (zero),
        .mem_done_i     (mem_done),
        .pc_wre_o       (PCWre),
        .ir_wre_o       (IRWre),
        .reg_wre_o      (RegWre),
        .ins_mem_rw_o   (InsMemRw),
        .m_rd_o         (mRD),
        .m_wr_o         (mWR),
        .alu_src_a_o    (ALUSrcA),
        .alu_src_b_o    (ALUSrcB),
        .ext_sel_o      (ExtSel),
        .db_data_src_o  (DBDataSrc),
        .wr_reg_d_src_o (WrRegDSrc),
        .reg_dst_o      (RegDst),
        .pc_src_o       (PcSrc),
        .alu_op_o       (alu_op3),
        .halted_o       (halted)
    );

    always_comb begin
        ALUOp      = '0;
        ALUOp[2:0] = alu_op3;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed scoreboard bench for multi_cycle_ctrl: expected per-cycle control words are queued, then popped at each negedge.
module tb_multi_cycle_ctrl;

    localparam logic [3:0] S_IF = 4'b0000, S_ID = 4'b0001, S_EXE_AL = 4'b0110, S_EXE_BR = 4'b0101;
    localparam logic [3:0] S_EXE_LS = 4'b0010, S_MEM = 4'b0011, S_WB_AL = 4'b0111, S_WB_LD = 4'b0100;
    localparam logic [3:0] S_HALT = 4'b1000;

    localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_ADDI = 6'b000010, O_OR = 6'b010000;
    localparam logic [5:0] O_AND = 6'b010001, O_ORI = 6'b010010, O_SLL = 6'b011000, O_SLT = 6'b100110;
    localparam logic [5:0] O_SW = 6'b110000, O_LW = 6'b110001, O_BEQ = 6'b110100, O_BNE = 6'b110101;
    localparam logic [5:0] O_J = 6'b111000, O_JR = 6'b111001, O_JAL = 6'b111010, O_HALT = 6'b111111;
    localparam logic [5:0] O_NOP = 6'b000111;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op;
    logic       PCWre, IRWre, RegWre, InsMemRw, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [1:0] RegDst, PcSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       halted;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.MEM_WAIT_EN(1), .ALUOP_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .InsMemRw(InsMemRw),
        .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
        .RegDst(RegDst), .PcSrc(PcSrc), .ALUOp(ALUOp), .state(state), .halted(halted)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       hlt, pcw, irw, rgw, imr, mrd, mwr;
        logic       asa, asb, ext, dbs, wrs;
        logic [1:0] rdst, pcs;
        logic [2:0] aop;
    } ctl_t;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic ctl_t observed();
        ctl_t c;
        c.st = state; c.hlt = halted; c.pcw = PCWre; c.irw = IRWre; c.rgw = RegWre;
        c.imr = InsMemRw; c.mrd = mRD; c.mwr = mWR; c.asa = ALUSrcA; c.asb = ALUSrcB;
        c.ext = ExtSel; c.dbs = DBDataSrc; c.wrs = WrRegDSrc; c.rdst = RegDst;
        c.pcs = PcSrc; c.aop = ALUOp;
        return c;
    endfunction

    // Datapath selects an opcode calls for outside IF/HALT.
    function automatic ctl_t sel(input logic [5:0] o);
        ctl_t c = '0;
        c.ext = (o != O_ORI);
        c.asa = (o == O_SLL);
        c.asb = (o == O_ADDI) || (o == O_ORI) || (o == O_LW) || (o == O_SW);
        c.dbs = (o == O_LW);
        c.wrs = (o == O_JAL);
        case (o)
            O_ADDI, O_ORI, O_LW:                      c.rdst = 2'b01;
            O_ADD, O_SUB, O_OR, O_AND, O_SLL, O_SLT:  c.rdst = 2'b10;
            default:                                  c.rdst = 2'b00;
        endcase
        case (o)
            O_SUB, O_BEQ, O_BNE: c.aop = 3'b001;
            O_SLL:               c.aop = 3'b010;
            O_OR, O_ORI:         c.aop = 3'b011;
            O_AND:               c.aop = 3'b100;
            O_SLT:               c.aop = 3'b101;
            default:             c.aop = 3'b000;
        endcase
        return c;
    endfunction

    function automatic ctl_t row(input logic [3:0] st, input logic [5:0] o);
        ctl_t c;
        c = (st == S_IF || st == S_HALT) ? ctl_t'('0) : sel(o);
        c.st = st;
        if (st == S_IF) begin
            c.irw = 1'b1;
            c.imr = 1'b1;
        end
        if (st == S_HALT) c.hlt = 1'b1;
        return c;
    endfunction

    task automatic push(input string t, input ctl_t e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic cmp_pop();
        ctl_t  e, o;
        string t;
        n_chk++;
        if (exp_q.size() == 0) begin
            $error("FAIL sb_empty observed=%h required=queued entry", observed());
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            assert (o === e) n_pass++;
            else $error("FAIL %s observed=%h required=%h", t, o, e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmp_pop();
        end
    endtask

    task automatic alu_instr(input logic [5:0] o, input string nm);
        ctl_t c;
        op = o;
        push({nm, "_ID"}, row(S_ID, o));
        push({nm, "_EXE"}, row(S_EXE_AL, o));
        c = row(S_WB_AL, o); c.rgw = 1'b1; c.pcw = 1'b1;
        push({nm, "_WB"}, c);
        push({nm, "_IF"}, row(S_IF, o));
        run(4);
    endtask

    task automatic br_instr(input logic [5:0] o, input logic z, input logic [1:0] pcs, input string nm);
        ctl_t c;
        op = o; zero = z;
        push({nm, "_ID"}, row(S_ID, o));
        c = row(S_EXE_BR, o); c.pcw = 1'b1; c.pcs = pcs;
        push({nm, "_BR"}, c);
        push({nm, "_IF"}, row(S_IF, o));
        run(3);
    endtask

    task automatic jmp_instr(input logic [5:0] o, input logic [1:0] pcs, input logic rgw, input string nm);
        ctl_t c;
        op = o;
        c = row(S_ID, o); c.pcw = 1'b1; c.pcs = pcs; c.rgw = rgw;
        push({nm, "_ID"}, c);
        push({nm, "_IF"}, row(S_IF, o));
        run(2);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        ctl_t c;
        reset = 1'b1; op = O_ADD; zero = 1'b0; mem_ready = 1'b1;

        push("reset", row(S_IF, O_ADD));
        run(1);
        reset = 1'b0;

        alu_instr(O_ADD, "add");
        alu_instr(O_ORI, "ori");
        alu_instr(O_SLL, "sll");
        alu_instr(O_SLT, "slt");
        alu_instr(O_ADDI, "addi");

        // lw with mem_ready low for the first three MEM cycles
        mem_ready = 1'b0; op = O_LW;
        push("lw_ID", row(S_ID, O_LW));
        push("lw_EXE", row(S_EXE_LS, O_LW));
        for (int i = 0; i < 4; i++) begin
            c = row(S_MEM, O_LW); c.mrd = 1'b1;
            push($sformatf("lw_MEM%0d", i), c);
        end
        run(6);
        mem_ready = 1'b1;
        c = row(S_WB_LD, O_LW); c.rgw = 1'b1; c.pcw = 1'b1;
        push("lw_WB", c);
        push("lw_IF", row(S_IF, O_LW));
        run(2);

        op = O_SW;
        push("sw_ID", row(S_ID, O_SW));
        push("sw_EXE", row(S_EXE_LS, O_SW));
        c = row(S_MEM, O_SW); c.mwr = 1'b1; c.pcw = 1'b1;
        push("sw_MEM", c);
        push("sw_IF", row(S_IF, O_SW));
        run(4);

        br_instr(O_BEQ, 1'b1, 2'b01, "beq_taken");
        br_instr(O_BEQ, 1'b0, 2'b00, "beq_not");
        br_instr(O_BNE, 1'b0, 2'b01, "bne_taken");
        br_instr(O_BNE, 1'b1, 2'b00, "bne_not");

        jmp_instr(O_JAL, 2'b11, 1'b1, "jal");
        jmp_instr(O_J, 2'b11, 1'b0, "j");
        jmp_instr(O_JR, 2'b10, 1'b0, "jr");
        jmp_instr(O_NOP, 2'b00, 1'b0, "nop");

        // sw stalled in MEM, then reset mid-access
        mem_ready = 1'b0; op = O_SW;
        push("swr_ID", row(S_ID, O_SW));
        push("swr_EXE", row(S_EXE_LS, O_SW));
        c = row(S_MEM, O_SW); c.mwr = 1'b1;
        push("swr_MEM", c);
        run(3);
        reset = 1'b1;
        #1;
        push("swr_reset", row(S_IF, O_SW));
        cmp_pop();

        op = O_HALT; mem_ready = 1'b1;
        push("rst_hold", row(S_IF, O_HALT));
        run(1);
        reset = 1'b0;
        push("halt_ID", row(S_ID, O_HALT));
        run(1);
        for (int i = 0; i < 20; i++) begin
            push($sformatf("halt_%0d", i), row(S_HALT, op));
            run(1);
            op = 6'($urandom_range(63, 0));
            zero = 1'($urandom_range(1, 0));
        end
        reset = 1'b1;
        #1;
        push("halt_reset", row(S_IF, op));
        cmp_pop();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
